dx_iobuf_sync: RTL
==================

DX_IOBUF_SYNC -- requirements
Module: dx_iobuf_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, number of independent bidirectional pad channels (1..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 1, consecutive stable cycles required before dio_o updates (1..255).
REQ-004 SHALL have parameter TURNAROUND, default 1, dead (Z) cycles inserted on input-to-output switch (0..15).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge) and rst input 1 (synchronous active-high reset).
REQ-006 SHALL have dio_t input DATA_WIDTH, per-channel direction request: 1 = input/Z, 0 = output.
REQ-007 SHALL have dio_i input DATA_WIDTH, output data to the pad.
REQ-008 SHALL have dio_o output DATA_WIDTH, synchronized and filtered pad value.
REQ-009 SHALL have dio_rise output DATA_WIDTH, 1-cycle pulse when dio_o goes 0->1.
REQ-010 SHALL have dio_fall output DATA_WIDTH, 1-cycle pulse when dio_o goes 1->0.
REQ-011 SHALL have dio_drv output DATA_WIDTH, 1 while the channel actively drives its pad.
REQ-012 SHALL have dio_p inout DATA_WIDTH, the bidirectional pad.

Function
REQ-013 Each channel SHALL be independent; no cross-channel interaction.
REQ-014 Per-channel direction FSM SHALL have states IN, TURN, OUT; pad driven only in OUT, else 1'bz.
REQ-015 IN: dio_t=0 sampled -> TURN when TURNAROUND>0, else directly to OUT; dio_t=1 -> stay IN.
REQ-016 TURN: dead-cycle counter loaded with TURNAROUND-1 on entry, decrements each cycle; dio_t=1 -> IN (abort, counter cleared); count 0 with dio_t=0 -> OUT.
REQ-017 OUT: dio_t=1 -> IN on the next edge (release without dead cycles); else stay OUT.
REQ-018 Pad drive latency: dio_t falling at edge n -> pad driven from edge n+TURNAROUND+1; dio_t rising at edge n -> pad Z from edge n+1.
REQ-019 dio_i SHALL be registered every cycle; driven pad value equals dio_i from the previous edge (latency 1).
REQ-020 dio_drv SHALL equal (state==OUT), registered, aligned with the pad enable.
REQ-021 Input path SHALL always sample dio_p (in all states, giving readback while driving) through a SYNC_STAGES flop chain.
REQ-022 Filter: per-channel 8-bit counter counts consecutive cycles where sync output != dio_o; dio_o toggles to sync value when the count reaches FILTER_CYCLES, counter then clears.
REQ-023 Any cycle with sync output == dio_o SHALL clear the filter counter (glitch rejection); counter SHALL NOT wrap.
REQ-024 Pad-to-dio_o latency for a clean step: SYNC_STAGES+FILTER_CYCLES cycles.
REQ-025 dio_rise/dio_fall SHALL assert in the same cycle dio_o changes, for exactly one cycle; never both at once.
REQ-026 Pad 'z'/'x' on the sampled input SHALL be treated by the sync chain as-is; the bench drives weak pull values only.

Reset
REQ-027 rst SHALL put every FSM in IN (pad Z), dio_drv=0, dio_o=0, dio_rise=0, dio_fall=0, sync chain=0, filter and dead-cycle counters=0, output data register=0.
REQ-028 rst asserted mid-TURN or mid-OUT SHALL release the pad to Z on the same edge; first drive after reset obeys REQ-018.
REQ-029 A pad held at 1 through reset SHALL produce dio_rise exactly once, SYNC_STAGES+FILTER_CYCLES cycles after rst deasserts.

Structure
REQ-030 Package dx_iobuf_pkg SHALL hold the FSM state typedef (IN/TURN/OUT), parameter range constants, and filter counter width (8).
REQ-031 One sub-module dx_iobuf_chan SHALL implement a single channel (FSM, sync, filter, edge detect, tristate), instantiated DATA_WIDTH times by a generate loop.
REQ-032 Parameter violations SHALL be flagged by elaboration-time assertions.

Verification
REQ-033 DATA_WIDTH=4, TURNAROUND=2: dio_t[0] 1->0 at edge 10 -> dio_p[0] Z at edges 11-12, driven at edge 13, dio_drv[0]=1 from 13; others Z.
REQ-034 TURNAROUND=3: dio_t 1->0 at edge 5, back to 1 at edge 6 -> pad never driven, dio_drv stays 0.
REQ-035 SYNC_STAGES=2, FILTER_CYCLES=3: pad 0->1 step at edge 20 -> dio_o=1 and dio_rise pulse at edge 25 only.
REQ-036 FILTER_CYCLES=3: 2-cycle high glitch on pad -> dio_o stays 0, no dio_rise/dio_fall.
REQ-037 Channel in OUT driving dio_i=1, rst at edge 40 -> pad Z and dio_drv=0 at edge 40, dio_o/pulses 0; after release dio_t=0 obeys REQ-018.
REQ-038 Random dio_t/dio_i/pad stimulus on 8 channels, 10k cycles -> scoreboard matches REQ-014..025; no cycle with both driver sides active.

Source files
------------

// File: rtl/dx_iobuf_pkg.sv
// Shared types and limits for the dx_iobuf bidirectional pad synchronizer.
package dx_iobuf_pkg;

    typedef enum logic [1:0] {
        ST_IN   = 2'd0,
        ST_TURN = 2'd1,
        ST_OUT  = 2'd2
    } dir_state_e;

    localparam int unsigned DW_MIN   = 1;
    localparam int unsigned DW_MAX   = 64;
    localparam int unsigned SYNC_MIN = 2;
    localparam int unsigned SYNC_MAX = 4;
    localparam int unsigned FILT_MIN = 1;
    localparam int unsigned FILT_MAX = 255;
    localparam int unsigned TURN_MAX = 15;

    localparam int unsigned FILT_W = 8;
    localparam int unsigned TURN_W = 4;

endpackage

// File: rtl/dx_iobuf_chan.sv
// One pad channel: direction FSM with dead cycles, registered output data,
// input synchronizer, stability filter and edge pulses.
module dx_iobuf_chan
    import dx_iobuf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter int unsigned TURNAROUND    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic dio_t,
    input  logic dio_i,
    output logic dio_o,
    output logic dio_rise,
    output logic dio_fall,
    output logic dio_drv,
    inout  wire  dio_p
);

    localparam logic [TURN_W-1:0] TURN_LOAD =
        (TURNAROUND == 0) ? '0 : TURN_W'(TURNAROUND - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

    dir_state_e              state_q, state_d;
    logic [TURN_W-1:0]       turn_cnt_q, turn_cnt_d;
    logic                    dout_q, dout_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [FILT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic                    dio_o_q, dio_o_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic                    sync_out;

    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            ST_IN: begin
                if (!dio_t) begin
                    if (TURNAROUND > 0) begin
                        state_d    = ST_TURN;
                        turn_cnt_d = TURN_LOAD;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_TURN: begin
                if (dio_t) begin
                    state_d    = ST_IN;
                    turn_cnt_d = '0;
                end else if (turn_cnt_q == '0) begin
                    state_d = ST_OUT;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            ST_OUT: begin
                if (dio_t) state_d = ST_IN;
            end
            default: begin
                state_d    = ST_IN;
                turn_cnt_d = '0;
            end
        endcase
    end

    // Pad is sampled in every state so a driven channel reads back its own value.
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        dout_d     = dio_i;
        sync_d     = {sync_q[SYNC_STAGES-2:0], dio_p};
        dio_o_d    = dio_o_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        filt_cnt_d = '0;
        if (sync_out != dio_o_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                dio_o_d = sync_out;
                rise_d  = sync_out;
                fall_d  = !sync_out;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IN;
            turn_cnt_q <= '0;
            dout_q     <= 1'b0;
            sync_q     <= '0;
            filt_cnt_q <= '0;
            dio_o_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            dout_q     <= dout_d;
            sync_q     <= sync_d;
            filt_cnt_q <= filt_cnt_d;
            dio_o_q    <= dio_o_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign dio_drv  = (state_q == ST_OUT);
    assign dio_p    = dio_drv ? dout_q : 1'bz;
    assign dio_o    = dio_o_q;
    assign dio_rise = rise_q;
    assign dio_fall = fall_q;

endmodule

// File: rtl/dx_iobuf_sync.sv
// Array of independent bidirectional pad channels with synchronized,
// glitch-filtered readback.
module dx_iobuf_sync
    import dx_iobuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter int unsigned TURNAROUND    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dio_t,
    input  logic [DATA_WIDTH-1:0] dio_i,
    output logic [DATA_WIDTH-1:0] dio_o,
    output logic [DATA_WIDTH-1:0] dio_rise,
    output logic [DATA_WIDTH-1:0] dio_fall,
    output logic [DATA_WIDTH-1:0] dio_drv,
    inout  wire  [DATA_WIDTH-1:0] dio_p
);

    if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_data_width
        $error("dx_iobuf_sync: DATA_WIDTH out of range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync_stages
        $error("dx_iobuf_sync: SYNC_STAGES out of range");
    end
    if (FILTER_CYCLES < FILT_MIN || FILTER_CYCLES > FILT_MAX) begin : g_bad_filter_cycles
        $error("dx_iobuf_sync: FILTER_CYCLES out of range");
    end
    if (TURNAROUND > TURN_MAX) begin : g_bad_turnaround
        $error("dx_iobuf_sync: TURNAROUND out of range");
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chan
        dx_iobuf_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .TURNAROUND   (TURNAROUND)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .dio_t   (dio_t[i]),
            .dio_i   (dio_i[i]),
            .dio_o   (dio_o[i]),
            .dio_rise(dio_rise[i]),
            .dio_fall(dio_fall[i]),
            .dio_drv (dio_drv[i]),
            .dio_p   (dio_p[i])
        );
    end

endmodule
